// File: rtl/jpeg_axil_regs_pkg.sv
// rtl/jpeg_axil_regs_pkg.sv - response codes, register map and FSM state types for the JPEG AXI-Lite register file
package jpeg_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int NUM_REGS = 4;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_SRC  = 2'd1;
  localparam logic [1:0] REG_DST  = 2'd2;
  localparam logic [1:0] REG_CFG  = 2'd3;

  // W_COMMIT is the cycle where address and data are both held and the write lands
  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_COMMIT,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_t;

  function automatic logic [1:0] resp_for(input logic mapped);
    return mapped ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/jpeg_axil_regs_if.sv
// rtl/jpeg_axil_regs_if.sv - AXI4-Lite control port bundle with master and slave views
interface jpeg_axil_regs_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic [2:0]            S_AXI_AWPROT;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [31:0]           S_AXI_WDATA;
  logic [3:0]            S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [2:0]            S_AXI_ARPROT;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [31:0]           S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface

// File: rtl/jpeg_axil_regs.sv
// rtl/jpeg_axil_regs.sv - AXI4-Lite slave holding the four JPEG core configuration registers
// Defining JPEG_AXIL_START_PULSE_EN adds start_pulse and makes reg_ctrl bit 0 self-clearing.
module jpeg_axil_regs
  import jpeg_axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic               ACLK,
  input  logic               ARESET,
  jpeg_axil_regs_if.slave    s_axi,
  output logic [31:0]        reg_ctrl,
  output logic [31:0]        reg_src,
  output logic [31:0]        reg_dst,
  output logic [31:0]        reg_cfg
`ifdef JPEG_AXIL_START_PULSE_EN
  ,
  output logic               start_pulse
`endif
);

  localparam int IW = ADDR_WIDTH - 2;

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("jpeg_axil_regs: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 4) begin : g_bad_addr_width
    $error("jpeg_axil_regs: ADDR_WIDTH must cover four word registers");
  end

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                  live;
  logic                  aw_ready, w_ready, b_valid, w_commit;
  logic                  ar_ready, r_valid;
  logic                  aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic [1:0]            b_resp, r_resp;
  logic [31:0]           r_data;
  logic [IW-1:0]         w_idx, r_idx;
  logic                  w_mapped, r_mapped;
  logic [31:0]           regs [NUM_REGS];

  assign aw_hs    = aw_ready && s_axi.S_AXI_AWVALID;
  assign w_hs     = w_ready && s_axi.S_AXI_WVALID;
  assign ar_hs    = ar_ready && s_axi.S_AXI_ARVALID;
  assign w_idx    = aw_addr[ADDR_WIDTH-1:2];
  assign r_idx    = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign w_mapped = 32'(w_idx) < 32'(NUM_REGS);
  assign r_mapped = 32'(r_idx) < 32'(NUM_REGS);

  // Holds every ready low until the first edge after reset is released
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) live <= 1'b0;
    else        live <= 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_COMMIT;
        else if (aw_hs)    w_next = W_HAVE_AW;
        else if (w_hs)     w_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  w_next = W_COMMIT;
      W_HAVE_W:  if (aw_hs) w_next = W_COMMIT;
      W_COMMIT:  w_next = W_RESP;
      W_RESP:    if (s_axi.S_AXI_BREADY) w_next = W_IDLE;
      default:   w_next = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    w_commit = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_ready = live;
        w_ready  = live;
      end
      W_HAVE_AW: w_ready  = 1'b1;
      W_HAVE_W:  aw_ready = 1'b1;
      W_COMMIT:  w_commit = 1'b1;
      W_RESP:    b_valid  = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      b_resp  <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_addr <= s_axi.S_AXI_AWADDR;
      if (w_hs) begin
        w_data <= s_axi.S_AXI_WDATA;
        w_strb <= s_axi.S_AXI_WSTRB;
      end
      if (w_commit) b_resp <= resp_for(w_mapped);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (w_commit && w_mapped) begin
        for (int b = 0; b < 4; b++) begin
          if (w_strb[b]) regs[w_idx[1:0]][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
`ifdef JPEG_AXIL_START_PULSE_EN
      regs[REG_CTRL][0] <= 1'b0;
`endif
    end
  end

`ifdef JPEG_AXIL_START_PULSE_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) start_pulse <= 1'b0;
    else        start_pulse <= w_commit && w_mapped && (w_idx[1:0] == REG_CTRL)
                               && w_strb[0] && w_data[0];
  end
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_RESP;
      R_RESP:  if (s_axi.S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    case (r_state)
      R_IDLE:  ar_ready = live;
      R_RESP:  r_valid  = 1'b1;
      default: ;
    endcase
  end

  // Reads sample the array before any same-edge commit, so they see the old value
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_data <= '0;
      r_resp <= RESP_OKAY;
    end else if (ar_hs) begin
      r_data <= r_mapped ? regs[r_idx[1:0]] : 32'h0;
      r_resp <= resp_for(r_mapped);
    end
  end

  assign s_axi.S_AXI_AWREADY = aw_ready;
  assign s_axi.S_AXI_WREADY  = w_ready;
  assign s_axi.S_AXI_BVALID  = b_valid;
  assign s_axi.S_AXI_BRESP   = b_resp;
  assign s_axi.S_AXI_ARREADY = ar_ready;
  assign s_axi.S_AXI_RVALID  = r_valid;
  assign s_axi.S_AXI_RDATA   = r_data;
  assign s_axi.S_AXI_RRESP   = r_resp;

  assign reg_ctrl = regs[REG_CTRL];
  assign reg_src  = regs[REG_SRC];
  assign reg_dst  = regs[REG_DST];
  assign reg_cfg  = regs[REG_CFG];

  logic unused;
  assign unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                    aw_addr[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule
